// File: rtl/gpio_pad_arbiter_if.sv
// rtl/gpio_pad_arbiter_if.sv - ownership request/grant handshake between a requester and the pad arbiter
interface gpio_pad_arbiter_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [5:0] req_pin_i;
  logic       req_owner_i;
  logic       done_o;
  logic       err_o;

  // Requester side: issues ownership-change requests and observes completion
  modport master (
    output req_valid_i, req_pin_i, req_owner_i,
    input  req_ready_o, done_o, err_o
  );

  // Arbiter side
  modport slave (
    input  req_valid_i, req_pin_i, req_owner_i,
    output req_ready_o, done_o, err_o
  );
endinterface

// File: rtl/gpio_pad_arbiter.sv
// rtl/gpio_pad_arbiter.sv - two-requester GPIO pad arbiter with guarded ownership handover (optional lock: GPIO_ARB_LOCK_EN)
module gpio_pad_arbiter #(
  parameter int NUM_GPIO     = 64,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_GPIO-1:0] a_gpio_out_i,
  input  logic [NUM_GPIO-1:0] a_gpio_dir_i,
  output logic [NUM_GPIO-1:0] a_gpio_in_o,
  input  logic [NUM_GPIO-1:0] b_gpio_out_i,
  input  logic [NUM_GPIO-1:0] b_gpio_dir_i,
  output logic [NUM_GPIO-1:0] b_gpio_in_o,
  output logic [NUM_GPIO-1:0] gpio_out_o,
  output logic [NUM_GPIO-1:0] gpio_dir_o,
  input  logic [NUM_GPIO-1:0] gpio_in_i,
  output logic [NUM_GPIO-1:0] owner_o,
`ifdef GPIO_ARB_LOCK_EN
  input  logic                lock_set_i,
`endif
  gpio_pad_arbiter_if.slave   req
);

  localparam int         CW        = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [6:0] NUM_PINS  = 7'(NUM_GPIO);
  localparam logic [CW-1:0] CNT_LOAD = CW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GUARD, DONE} state_t;

  state_t                state_q, state_d;
  logic [NUM_GPIO-1:0]   owner_q, owner_d;
  logic [5:0]            pin_q, pin_d;
  logic                  new_owner_q, new_owner_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  locked_q;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [NUM_GPIO-1:0]   guard_mask;

`ifdef GPIO_ARB_LOCK_EN
  // Sticky lock: once set only reset releases the ownership table
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) locked_q <= 1'b0;
    else if (lock_set_i) locked_q <= 1'b1;
  end
`else
  assign locked_q = 1'b0;
`endif

  // State and request context registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      pin_q       <= '0;
      new_owner_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      pin_q       <= pin_d;
      new_owner_q <= new_owner_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and handshake outputs; ownership only changes at the end of the guard window
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    pin_d       = pin_q;
    new_owner_d = new_owner_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    ready       = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req.req_valid_i) begin
          pin_d       = req.req_pin_i;
          new_owner_d = req.req_owner_i;
          err_d       = 1'b0;
          if (({1'b0, req.req_pin_i} >= NUM_PINS) || locked_q) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (owner_q[req.req_pin_i] == req.req_owner_i) begin
            state_d = DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = GUARD;
          end
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          owner_d[pin_q] = new_owner_q;
          state_d        = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Only the pin under handover is forced to input
  always_comb begin
    guard_mask = '0;
    if (state_q == GUARD) guard_mask[pin_q] = 1'b1;
  end

  assign gpio_out_o  = (owner_q & b_gpio_out_i) | (~owner_q & a_gpio_out_i);
  assign gpio_dir_o  = ((owner_q & b_gpio_dir_i) | (~owner_q & a_gpio_dir_i)) & ~guard_mask;
  assign a_gpio_in_o = gpio_in_i & ~owner_q;
  assign b_gpio_in_o = gpio_in_i & owner_q;
  assign owner_o     = owner_q;

  assign req.req_ready_o = ready;
  assign req.done_o      = done;
  assign req.err_o       = err;

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// tb/tb_gpio_pad_arbiter.sv - directed self-checking bench for gpio_pad_arbiter
module tb_gpio_pad_arbiter;
  localparam int N = 58;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] a_out, a_dir, a_in, b_out, b_dir, b_in;
  logic [N-1:0] pad_out, pad_dir, pad_in, owner;
  logic         lock_set;
  int           total = 0;
  int           bad = 0;

  logic [N-1:0] a_pat, b_pat, all1, m5, m7;

  gpio_pad_arbiter_if rq ();

  gpio_pad_arbiter #(.NUM_GPIO(N), .GUARD_CYCLES(G)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .a_gpio_out_i (a_out),
    .a_gpio_dir_i (a_dir),
    .a_gpio_in_o  (a_in),
    .b_gpio_out_i (b_out),
    .b_gpio_dir_i (b_dir),
    .b_gpio_in_o  (b_in),
    .gpio_out_o   (pad_out),
    .gpio_dir_o   (pad_dir),
    .gpio_in_i    (pad_in),
    .owner_o      (owner),
`ifdef GPIO_ARB_LOCK_EN
    .lock_set_i   (lock_set),
`endif
    .req          (rq.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_pat = {29{2'b10}};
    b_pat = {29{2'b01}};
    all1  = '1;
    m5    = '0; m5[5] = 1'b1;
    m7    = '0; m7[7] = 1'b1;

    rst_n = 1'b0;
    lock_set = 1'b0;
    a_out = a_pat; a_dir = all1;
    b_out = b_pat; b_dir = all1;
    pad_in = all1;
    rq.req_valid_i = 1'b0; rq.req_pin_i = '0; rq.req_owner_i = 1'b0;
    #12;
    check("rst_ready", 64'(rq.req_ready_o), 64'd1);
    check("rst_done",  64'(rq.done_o), 64'd0);
    check("rst_err",   64'(rq.err_o), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_out",   64'(pad_out), 64'(a_pat));
    check("rst_b_in",  64'(b_in), 64'd0);
    check("rst_a_in",  64'(a_in), 64'(all1));
    tick();
    rst_n = 1'b1;
    tick();

    // Handover pin 5 to B; accept edge is T
    rq.req_valid_i = 1'b1; rq.req_pin_i = 6'd5; rq.req_owner_i = 1'b1;
    #1;
    check("h_ready_pre", 64'(rq.req_ready_o), 64'd1);
    tick();
    rq.req_valid_i = 1'b0;
    for (int k = 1; k <= G; k++) begin
      check($sformatf("h_guard_dir_%0d", k), 64'(pad_dir), 64'(all1 & ~m5));
      check($sformatf("h_guard_done_%0d", k), 64'(rq.done_o), 64'd0);
      check($sformatf("h_guard_ready_%0d", k), 64'(rq.req_ready_o), 64'd0);
      check($sformatf("h_guard_owner_%0d", k), 64'(owner), 64'd0);
      if (k < G) tick();
    end
    tick();
    check("h_done",  64'(rq.done_o), 64'd1);
    check("h_err",   64'(rq.err_o), 64'd0);
    check("h_owner", 64'(owner), 64'(m5));
    check("h_out",   64'(pad_out), 64'((a_pat & ~m5) | (b_pat & m5)));
    check("h_dir",   64'(pad_dir), 64'(all1));
    check("h_a_in",  64'(a_in), 64'(all1 & ~m5));
    check("h_b_in",  64'(b_in), 64'(m5));
    check("h_ready_done", 64'(rq.req_ready_o), 64'd0);
    tick();
    check("h_ready_back", 64'(rq.req_ready_o), 64'd1);
    check("h_done_clr",   64'(rq.done_o), 64'd0);
    b_dir = all1 & ~m5;
    #1;
    check("h_dir_follow_b", 64'(pad_dir), 64'(all1 & ~m5));

    // Repeat request on pin 5 -> B is a no-op
    rq.req_valid_i = 1'b1; rq.req_pin_i = 6'd5; rq.req_owner_i = 1'b1;
    tick();
    rq.req_valid_i = 1'b0;
    check("noop_done",  64'(rq.done_o), 64'd1);
    check("noop_err",   64'(rq.err_o), 64'd0);
    check("noop_dir",   64'(pad_dir), 64'(all1 & ~m5));
    check("noop_owner", 64'(owner), 64'(m5));
    tick();
    check("noop_ready", 64'(rq.req_ready_o), 64'd1);
    b_dir = all1;

    // Out-of-range pins are rejected
    rq.req_valid_i = 1'b1; rq.req_pin_i = 6'd63; rq.req_owner_i = 1'b1;
    tick();
    rq.req_valid_i = 1'b0;
    check("err63_done",  64'(rq.done_o), 64'd1);
    check("err63_err",   64'(rq.err_o), 64'd1);
    check("err63_owner", 64'(owner), 64'(m5));
    tick();
    check("err63_ready", 64'(rq.req_ready_o), 64'd1);
    rq.req_valid_i = 1'b1; rq.req_pin_i = 6'd58; rq.req_owner_i = 1'b1;
    tick();
    rq.req_valid_i = 1'b0;
    check("err58_err",   64'(rq.err_o), 64'd1);
    check("err58_owner", 64'(owner), 64'(m5));
    tick();

    // Reset in the middle of a handover on pin 7; req changes during GUARD are ignored
    rq.req_valid_i = 1'b1; rq.req_pin_i = 6'd7; rq.req_owner_i = 1'b1;
    tick();
    rq.req_pin_i = 6'd9;
    tick();
    check("rg_dir",   64'(pad_dir), 64'(all1 & ~m7));
    check("rg_ready", 64'(rq.req_ready_o), 64'd0);
    rq.req_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rg_owner", 64'(owner), 64'd0);
    check("rg_ready_rst", 64'(rq.req_ready_o), 64'd1);
    check("rg_dir_rst", 64'(pad_dir), 64'(all1));
    check("rg_out_rst", 64'(pad_out), 64'(a_pat));
    tick();
    rst_n = 1'b1;
    tick();

`ifdef GPIO_ARB_LOCK_EN
    lock_set = 1'b1;
    tick();
    lock_set = 1'b0;
    rq.req_valid_i = 1'b1; rq.req_pin_i = 6'd2; rq.req_owner_i = 1'b1;
    tick();
    rq.req_valid_i = 1'b0;
    check("lock_done",  64'(rq.done_o), 64'd1);
    check("lock_err",   64'(rq.err_o), 64'd1);
    check("lock_owner", 64'(owner), 64'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
